// File: rtl/mul8s_pkg.sv
// Shared types and constants for the mul8s stimulus generator / error checker.
package mul8s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;
    localparam int ERR_W = 17;

    // Fibonacci taps 16,14,13,11 expressed as state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [ERR_W-1:0] EXH_VECS = 17'd65536;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mul8s_err_acc.sv
// Aligns the issue-time exact product with the DUT result and accumulates error metrics.
module mul8s_err_acc
    import mul8s_pkg::*;
#(
    parameter int DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [RES_W-1:0] exact,
    input  logic [RES_W-1:0] O,
    output logic [ERR_W-1:0] vec_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      sum_abs_err,
    output logic [ERR_W-1:0] max_abs_err
);

    logic [DUT_LAT:0]   dl_valid;
    logic [RES_W-1:0]   dl_exact [DUT_LAT+1];
    logic [ERR_W-1:0]   diff;
    logic [ERR_W-1:0]   abs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid <= '0;
            for (int k = 0; k <= DUT_LAT; k++) dl_exact[k] <= '0;
        end else begin
            dl_valid[0] <= valid;
            dl_exact[0] <= exact;
            for (int k = 1; k <= DUT_LAT; k++) begin
                dl_valid[k] <= dl_valid[k-1];
                dl_exact[k] <= dl_exact[k-1];
            end
        end
    end

    // 17-bit signed difference cannot overflow: |d| <= 49152
    assign diff  = {dl_exact[DUT_LAT][RES_W-1], dl_exact[DUT_LAT]} - {O[RES_W-1], O};
    assign abs_d = diff[ERR_W-1] ? (~diff + ERR_W'(1)) : diff;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec_cnt     <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (dl_valid[DUT_LAT]) begin
            vec_cnt     <= vec_cnt + ERR_W'(1);
            if (abs_d != '0) err_cnt <= err_cnt + ERR_W'(1);
            sum_abs_err <= sum_abs_err + 32'(abs_d);
            if (abs_d > max_abs_err) max_abs_err <= abs_d;
        end
    end

endmodule

// File: rtl/mul8s_stim_checker.sv
// Drives exhaustive or LFSR-random operand pairs into a mul8s DUT and checks O against A*B.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | issuing one vector per cycle
//   DRAIN | waiting for the last 1+DUT_LAT samples to land
//   DONE  | metrics final and stable, waiting for start
module mul8s_stim_checker
    import mul8s_pkg::*;
#(
    parameter int          DUT_LAT  = 0,
    parameter int          NUM_RAND = 4096,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic [7:0]  A,
    output logic [7:0]  B,
    input  logic [15:0] O,
    output logic        busy,
    output logic        done,
    output logic [16:0] vec_cnt,
    output logic [16:0] err_cnt,
    output logic [31:0] sum_abs_err,
    output logic [16:0] max_abs_err
);

    localparam int               DRAIN_W   = $clog2(DUT_LAT + 2);
    localparam logic [ERR_W-1:0] RAND_VECS = ERR_W'(NUM_RAND);

    state_t               state, state_next;
    logic                 launch, issue;
    logic                 mode_q;
    logic [15:0]          lfsr;
    logic [ERR_W-1:0]     issue_cnt;
    logic [ERR_W-1:0]     n_vec;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [15:0]          vec;
    logic [RES_W-1:0]     a_ext, b_ext, exact;

    assign n_vec = mode_q ? RAND_VECS : EXH_VECS;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    launch     = 1'b1;
                    issue      = 1'b1;
                end
            end
            RUN: begin
                if (issue_cnt == n_vec) state_next = DRAIN;
                else                    issue      = 1'b1;
            end
            DRAIN: begin
                if (drain_cnt == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // lfsr always holds the next random vector to issue
    always_comb begin
        vec = issue_cnt[15:0];
        if (launch)      vec = mode ? SEED : 16'd0;
        else if (mode_q) vec = lfsr;
    end

    assign a_ext = {{8{vec[15]}}, vec[15:8]};
    assign b_ext = {{8{vec[7]}}, vec[7:0]};
    assign exact = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= 1'b0;
            lfsr      <= SEED;
            issue_cnt <= '0;
            drain_cnt <= '0;
            A         <= '0;
            B         <= '0;
        end else begin
            if (launch) begin
                mode_q    <= mode;
                lfsr      <= lfsr_next(SEED);
                issue_cnt <= ERR_W'(1);
            end else if (issue) begin
                lfsr      <= lfsr_next(lfsr);
                issue_cnt <= issue_cnt + ERR_W'(1);
            end
            if (issue) begin
                A <= vec[15:8];
                B <= vec[7:0];
            end
            if (state == RUN)
                drain_cnt <= DRAIN_W'(DUT_LAT);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end

    mul8s_err_acc #(.DUT_LAT(DUT_LAT)) u_err_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (launch),
        .valid       (issue),
        .exact       (exact),
        .O           (O),
        .vec_cnt     (vec_cnt),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err)
    );

endmodule
